bc_trigger_tagger: RTL and testbench
====================================

Name: bc_trigger_tagger

Overview:
Downstream consumer of the bunch counter value. Extends the free-running BC into an {orbit, BC} timestamp by counting BC wrap-arounds. Tags each rising edge of the trigger input with that timestamp and buffers the tags in a small FIFO. The readout logic drains the FIFO through a valid/ready interface.

Parameters:
BITS, 12, width of incoming bunch counter; wrap value is 2^BITS-1 -> 0
ORBIT_BITS, 16, width of orbit counter
DEPTH, 8, FIFO entries; power of two, >= 2
DEADTIME, 4, trigger holdoff in cycles (used only with TRIG_DEADTIME_EN)

Ports:
CLK  in  1  single clock; all logic on rising edge
RST_N  in  1  synchronous, active-low reset
BC  in  BITS  bunch counter value, advances by 1 per cycle when running
TRIG  in  1  trigger level, synchronous to CLK
OUT_DATA  out  ORBIT_BITS+BITS  head tag, {orbit, bc}; orbit in MSBs
OUT_VALID  out  1  FIFO non-empty
OUT_READY  in  1  consumer accepts head when OUT_VALID & OUT_READY
FULL  out  1  FIFO holds DEPTH entries
OVERFLOW  out  1  sticky: a trigger was dropped because the FIFO was full
DROP_COUNT  out  8  number of dropped triggers, saturates at 255

Behaviour:
- Reset (RST_N=0 sampled at edge): orbit=0, bc_prev=0, trig_d=0, FIFO empty, OVERFLOW=0, DROP_COUNT=0, deadtime counter=0. All outputs read back reset values after that edge: OUT_VALID=0, FULL=0, OUT_DATA=0. Reset mid-operation discards all buffered tags.
- Wrap detect: wrap = (BC==0) & (bc_prev==2^BITS-1); bc_prev <= BC every cycle. The first BC=0 after reset is not a wrap.
- Orbit: orbit <= orbit+1 on wrap, modulo 2^ORBIT_BITS; all-ones -> 0 with no flag.
- Trigger event: trig_ev = TRIG & ~trig_d; trig_d <= TRIG. A held-high TRIG yields exactly one event.
- Tag = {orbit_now, BC}, where orbit_now = wrap ? orbit+1 : orbit. A tag taken on the wrap cycle therefore reads {orbit+1, 0}.
- Write at the edge where trig_ev is sampled, if not full, or if full and a read happens in the same cycle.
- Latency: OUT_VALID is high in the cycle after the write edge, with OUT_DATA equal to the tag.
- Read: head pops at an edge where OUT_VALID & OUT_READY. OUT_DATA is combinational from mem[rd_ptr] and is stable while OUT_VALID & ~OUT_READY. OUT_READY with OUT_VALID=0 has no effect.
- Simultaneous read+write: occupancy unchanged; when empty, write only (no bypass).
- Full and trig_ev with no read: tag dropped, OVERFLOW <= 1, DROP_COUNT <= min(DROP_COUNT+1, 255). Occupancy unchanged.
- OVERFLOW and DROP_COUNT clear only on reset.
- FULL = (count==DEPTH); OUT_VALID = (count!=0); count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

Optional Feature:
TRIG_DEADTIME_EN.
- Defined: after an accepted trigger, a down-counter loads DEADTIME. While it is non-zero, trig_ev is ignored: no write, not counted as a drop. The counter decrements each cycle. A trigger edge arriving on the cycle the counter reaches 0 is accepted.
- Undefined: every trig_ev is processed as above; no counter is present.

Test Plan:
- Reset, then BC stepping 0..4095, 0..4095, 0 -> orbit 0 on the first pass, 1 after the first wrap, 2 after the second. TRIG pulse at BC=100 in orbit 2 -> OUT_DATA=0x0002_064, OUT_VALID high one cycle after the edge sample.
- TRIG rises on the cycle BC=0 following BC=4095, orbit was 5 -> tag {6, 0}.
- TRIG held high for 20 cycles -> exactly one entry.
- OUT_READY=0, 9 separate trigger edges, DEPTH=8 -> FULL=1, 8 entries in order, OVERFLOW=1, DROP_COUNT=1. Then drain with OUT_READY=1 -> 8 pops in write order, OUT_VALID low after the last.
- FIFO full, trig_ev and pop in the same cycle -> no drop, count stays 8, new tag at the tail. Reset asserted with 3 entries -> OUT_VALID=0, OVERFLOW=0, DROP_COUNT=0 after the edge.
- TRIG_DEADTIME_EN, DEADTIME=4: edges at cycles 0, 2, 4 -> entries for cycles 0 and 4 only, DROP_COUNT stays 0. Without the macro -> 3 entries.

Source files
------------

// File: rtl/bc_trigger_tagger.sv
// Extends the bunch counter into an {orbit, BC} timestamp and queues one tag per TRIG rising edge.
// Define TRIG_DEADTIME_EN to add a DEADTIME-cycle holdoff after each accepted trigger.
module bc_trigger_tagger #(
  parameter int BITS       = 12,
  parameter int ORBIT_BITS = 16,
  parameter int DEPTH      = 8,
  parameter int DEADTIME   = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [BITS-1:0]            BC,
  input  logic                       TRIG,
  output logic [ORBIT_BITS+BITS-1:0] OUT_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic                       FULL,
  output logic                       OVERFLOW,
  output logic [7:0]                 DROP_COUNT
);

  localparam int TAG_W = ORBIT_BITS + BITS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [BITS-1:0]       bc_prev;
  logic [ORBIT_BITS-1:0] orbit;
  logic [ORBIT_BITS-1:0] orbit_now;
  logic                  trig_d;
  logic                  wrap;
  logic                  trig_ev;
  logic                  holdoff;
  logic                  rd_en;
  logic                  wr_en;
  logic                  drop;
  logic [TAG_W-1:0]      tag_p0;
  logic [TAG_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // Stage p0: wrap detection, edge detection and tag formation
  assign wrap      = (BC == '0) && (bc_prev == {BITS{1'b1}});
  assign orbit_now = wrap ? orbit + ORBIT_BITS'(1) : orbit;
  assign tag_p0    = {orbit_now, BC};
  assign trig_ev   = TRIG & ~trig_d & ~holdoff;

  assign OUT_VALID = (count != '0);
  assign FULL      = (count == CNT_W'(DEPTH));
  assign rd_en     = OUT_VALID & OUT_READY;
  // A full FIFO still takes a tag when the head pops on the same edge
  assign wr_en     = trig_ev & (~FULL | rd_en);
  assign drop      = trig_ev & FULL & ~rd_en;
  // Empty FIFO presents zero rather than stale storage
  assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;

`ifdef TRIG_DEADTIME_EN
  localparam int DT_W = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
  logic [DT_W-1:0] dt_cnt;

  // An edge seen while the counter is stepping 1 -> 0 is already outside the holdoff
  assign holdoff = (dt_cnt > DT_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dt_cnt <= '0;
    end else if (wr_en) begin
      dt_cnt <= DT_W'(DEADTIME);
    end else if (dt_cnt != '0) begin
      dt_cnt <= dt_cnt - DT_W'(1);
    end
  end
`else
  assign holdoff = 1'b0;
`endif

  // Stage p1: timestamp state, FIFO control and drop accounting
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bc_prev    <= '0;
      orbit      <= '0;
      trig_d     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      OVERFLOW   <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      bc_prev <= BC;
      trig_d  <= TRIG;
      if (wrap) begin
        orbit <= orbit + ORBIT_BITS'(1);
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      if (drop) begin
        OVERFLOW   <= 1'b1;
        DROP_COUNT <= sat_inc8(DROP_COUNT);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= tag_p0;
    end
  end

endmodule

// File: tb/tb_bc_trigger_tagger.sv
// Directed bench for bc_trigger_tagger: vector table plus multi-cycle sequences
// for orbit extension, FIFO full/overflow, reset flush and trigger holdoff.
module tb_bc_trigger_tagger;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [11:0] BC = '0;
  logic        TRIG = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [27:0] OUT_DATA;
  logic        OUT_VALID;
  logic        FULL;
  logic        OVERFLOW;
  logic [7:0]  DROP_COUNT;

  bc_trigger_tagger #(.BITS(12), .ORBIT_BITS(16), .DEPTH(8), .DEADTIME(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .BC(BC), .TRIG(TRIG),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .FULL(FULL), .OVERFLOW(OVERFLOW), .DROP_COUNT(DROP_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic [11:0] bc;
    logic        trig;
    logic        rdy;
    logic        v;
    logic [27:0] d;
    logic        f;
    logic        o;
    logic [7:0]  dc;
  } vec_t;

  vec_t        vecs [14];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] bc_cur  = '0;
  logic [27:0] exp_q [$];
  logic [27:0] new_tag;
  logic [27:0] last_pop;
  logic [11:0] bc_a;
  logic [11:0] bc_b;
  int          n_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic t, input logic r);
    BC = bc_cur;
    TRIG = t;
    OUT_READY = r;
    @(posedge CLK);
    #1;
    bc_cur = bc_cur + 12'd1;
  endtask

  task automatic pulse(input logic r);
    tick(1'b1, r);
    repeat (4) tick(1'b0, r);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    BC = '0;
    TRIG = 1'b0;
    OUT_READY = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    bc_cur = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst  bc        trig  rdy   v     data          full  ovf   drop
    vecs[0]  = '{1'b0, 12'd0,    1'b0, 1'b0, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 12'd0,    1'b0, 1'b0, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 12'd1,    1'b1, 1'b0, 1'b1, 28'h0000001, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 12'd2,    1'b1, 1'b0, 1'b1, 28'h0000001, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 12'd3,    1'b0, 1'b1, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 12'd4095, 1'b0, 1'b0, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 12'd0,    1'b1, 1'b0, 1'b1, 28'h0001000, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 12'd1,    1'b0, 1'b0, 1'b1, 28'h0001000, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 12'd2,    1'b0, 1'b1, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 12'd3,    1'b0, 1'b1, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 12'd4,    1'b0, 1'b1, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 12'd5,    1'b1, 1'b1, 1'b1, 28'h0001005, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 12'd6,    1'b0, 1'b1, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 12'd7,    1'b0, 1'b0, 1'b0, 28'h0000000, 1'b0, 1'b0, 8'd0};

    for (int i = 0; i < 14; i++) begin
      RST_N = vecs[i].rst_n;
      BC = vecs[i].bc;
      TRIG = vecs[i].trig;
      OUT_READY = vecs[i].rdy;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(OUT_VALID), 64'(vecs[i].v));
      chk($sformatf("vec%0d_data", i), 64'(OUT_DATA), 64'(vecs[i].d));
      chk($sformatf("vec%0d_full", i), 64'(FULL), 64'(vecs[i].f));
      chk($sformatf("vec%0d_ovf", i), 64'(OVERFLOW), 64'(vecs[i].o));
      chk($sformatf("vec%0d_drop", i), 64'(DROP_COUNT), 64'(vecs[i].dc));
    end

    // Two full BC passes, then a trigger at BC=100 in orbit 2
    do_reset();
    repeat (8192) tick(1'b0, 1'b0);
    repeat (100) tick(1'b0, 1'b0);
    chk("orbit2_pre_valid", 64'(OUT_VALID), 64'd0);
    tick(1'b1, 1'b0);
    chk("orbit2_valid", 64'(OUT_VALID), 64'd1);
    chk("orbit2_data", 64'(OUT_DATA), 64'h0002064);
    tick(1'b0, 1'b1);
    chk("orbit2_popped", 64'(OUT_VALID), 64'd0);

    // Advance to the end of orbit 5 and trigger on the wrap cycle
    while (bc_cur != 12'd0) tick(1'b0, 1'b0);
    repeat (3 * 4096) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("wrap_tag_valid", 64'(OUT_VALID), 64'd1);
    chk("wrap_tag_data", 64'(OUT_DATA), 64'h0006000);
    tick(1'b0, 1'b1);

    // Held trigger produces one entry
    bc_a = bc_cur;
    repeat (20) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("held_valid", 64'(OUT_VALID), 64'd1);
    chk("held_data", 64'(OUT_DATA), 64'({16'd6, bc_a}));
    tick(1'b0, 1'b1);
    chk("held_single", 64'(OUT_VALID), 64'd0);

    // Nine edges into an eight-deep FIFO with no reads
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({16'd0, bc_cur});
      pulse(1'b0);
    end
    chk("fill_full", 64'(FULL), 64'd1);
    chk("fill_valid", 64'(OUT_VALID), 64'd1);
    chk("fill_ovf", 64'(OVERFLOW), 64'd1);
    chk("fill_drop", 64'(DROP_COUNT), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_data", i), 64'(OUT_DATA), 64'(exp_q[i]));
      tick(1'b0, 1'b1);
    end
    chk("drain_empty", 64'(OUT_VALID), 64'd0);
    chk("drain_full", 64'(FULL), 64'd0);
    chk("drain_ovf_sticky", 64'(OVERFLOW), 64'd1);

    // Full FIFO: write and pop on the same edge
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({16'd0, bc_cur});
      pulse(1'b0);
    end
    new_tag = {16'd0, bc_cur};
    tick(1'b1, 1'b1);
    chk("rw_full", 64'(FULL), 64'd1);
    chk("rw_drop", 64'(DROP_COUNT), 64'd0);
    chk("rw_ovf", 64'(OVERFLOW), 64'd0);
    void'(exp_q.pop_front());
    exp_q.push_back(new_tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rw_drain%0d_data", i), 64'(OUT_DATA), 64'(exp_q[i]));
      tick(1'b0, 1'b1);
    end
    chk("rw_drain_empty", 64'(OUT_VALID), 64'd0);

    // Reset flushes three buffered tags and clears overflow state
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({16'd0, bc_cur});
      pulse(1'b0);
    end
    repeat (5) tick(1'b0, 1'b1);
    chk("pre_rst_head", 64'(OUT_DATA), 64'(exp_q[5]));
    chk("pre_rst_ovf", 64'(OVERFLOW), 64'd1);
    RST_N = 1'b0;
    tick(1'b0, 1'b0);
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_full", 64'(FULL), 64'd0);
    chk("rst_data", 64'(OUT_DATA), 64'd0);
    chk("rst_ovf", 64'(OVERFLOW), 64'd0);
    chk("rst_drop", 64'(DROP_COUNT), 64'd0);
    RST_N = 1'b1;

    // Trigger edges two cycles apart
    do_reset();
    bc_a = bc_cur;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    bc_b = bc_cur;
    tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    chk("dt_drop", 64'(DROP_COUNT), 64'd0);
    chk("dt_first", 64'(OUT_DATA), 64'({16'd0, bc_a}));
    n_pop = 0;
    last_pop = '0;
    for (int i = 0; i < 6; i++) begin
      if (OUT_VALID) begin
        n_pop++;
        last_pop = OUT_DATA;
      end
      tick(1'b0, 1'b1);
    end
`ifdef TRIG_DEADTIME_EN
    chk("dt_entries", 64'(n_pop), 64'd2);
`else
    chk("dt_entries", 64'(n_pop), 64'd3);
`endif
    chk("dt_last", 64'(last_pop), 64'({16'd0, bc_b}));
    chk("dt_empty", 64'(OUT_VALID), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
